// File: rtl/neutral_trinary_array.sv
`timescale 1ns/1ps
// Array of trinary cells (POS/NEG/UNS) that, after a batch load, collapses every UNS cell
// one per resolution step, lowest index first, using the mode captured when the batch was accepted.
module neutral_trinary_array #(
  parameter int          N_CH = 8,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int          DW   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [2*N_CH-1:0]         load_data,
  input  logic [1:0]                load_mode,
  input  logic [DW-1:0]             load_dwell,
  input  logic                      abort,
  output logic [2*N_CH-1:0]         state_o,
  output logic                      all_resolved,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(N_CH+1)-1:0] resolve_cnt,
  output logic [1:0]                dbg_state_o,
  output logic [15:0]               dbg_lfsr_o
);

  localparam int CW = $clog2(N_CH + 1);
  localparam logic [1:0] CELL_POS = 2'b00;
  localparam logic [1:0] CELL_NEG = 2'b01;
  localparam logic [1:0] CELL_UNS = 2'b10;
  localparam logic [1:0] MODE_RANDOM    = 2'b00;
  localparam logic [1:0] MODE_FORCE_POS = 2'b01;
  localparam logic [1:0] MODE_FORCE_NEG = 2'b10;
  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_C = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Load port handshake: a batch transfers on a clock edge where load_valid && load_ready;
  // load_ready is high only in IDLE, and load_valid seen in any other state is dropped.

  state_t              state_q, state_d;
  logic [2*N_CH-1:0]   cells_q, cells_d;
  logic [1:0]          mode_q, mode_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [DW-1:0]       dwell_cnt_q, dwell_cnt_d;
  logic [CW-1:0]       rcnt_q, rcnt_d;
  logic [15:0]         lfsr_q, lfsr_d;

  logic                any_uns;
  logic [N_CH-1:0]     first_uns;
  logic [CW-1:0]       pos_cnt, neg_cnt;
  logic                rbit;
  logic [1:0]          res_val;
  logic                lfsr_fb;

  assign rbit    = lfsr_q[0];
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // Scan downwards so the lowest-index UNS cell is the one left in first_uns.
  always_comb begin
    any_uns   = 1'b0;
    first_uns = '0;
    pos_cnt   = '0;
    neg_cnt   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (cells_q[2*i +: 2] == CELL_UNS) begin
        any_uns   = 1'b1;
        first_uns = '0;
        first_uns[i] = 1'b1;
      end
      if (cells_q[2*i +: 2] == CELL_POS) pos_cnt = pos_cnt + CW'(1);
      if (cells_q[2*i +: 2] == CELL_NEG) neg_cnt = neg_cnt + CW'(1);
    end
  end

  always_comb begin
    res_val = CELL_POS;
    case (mode_q)
      MODE_RANDOM:    res_val = rbit ? CELL_NEG : CELL_POS;
      MODE_FORCE_POS: res_val = CELL_POS;
      MODE_FORCE_NEG: res_val = CELL_NEG;
      default: begin
        // BALANCE pushes toward the minority polarity; ties go to the LFSR.
        if (pos_cnt > neg_cnt)      res_val = CELL_NEG;
        else if (neg_cnt > pos_cnt) res_val = CELL_POS;
        else                        res_val = rbit ? CELL_NEG : CELL_POS;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cells_q     <= {N_CH{CELL_UNS}};
      mode_q      <= 2'b00;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      rcnt_q      <= '0;
      lfsr_q      <= SEED_C;
    end else begin
      state_q     <= state_d;
      cells_q     <= cells_d;
      mode_q      <= mode_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      rcnt_q      <= rcnt_d;
      lfsr_q      <= lfsr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cells_d     = cells_q;
    mode_d      = mode_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    rcnt_d      = rcnt_q;
    lfsr_d      = {lfsr_fb, lfsr_q[15:1]};
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          for (int i = 0; i < N_CH; i++) begin
            cells_d[2*i +: 2] = (load_data[2*i +: 2] == 2'b11) ? CELL_UNS : load_data[2*i +: 2];
          end
          mode_d      = load_mode;
          dwell_d     = load_dwell;
          dwell_cnt_d = load_dwell;
          rcnt_d      = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!any_uns) begin
          state_d = S_DONE;
        end else if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - DW'(1);
        end else begin
          for (int i = 0; i < N_CH; i++) begin
            if (first_uns[i]) cells_d[2*i +: 2] = res_val;
          end
          dwell_cnt_d = dwell_q;
          rcnt_d      = rcnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready   = (state_q == S_IDLE);
    busy         = (state_q == S_RUN) || (state_q == S_DONE);
    done         = (state_q == S_DONE);
    state_o      = cells_q;
    all_resolved = !any_uns;
    resolve_cnt  = rcnt_q;
    dbg_state_o  = state_q;
    dbg_lfsr_o   = lfsr_q;
  end

endmodule

// File: tb/tb_neutral_trinary_array.sv
`timescale 1ns/1ps
// Bench for neutral_trinary_array (N_CH=4): directed batches checked against a timeline model
// every cycle, plus literal expectations for the hand-worked scenarios.
module tb_neutral_trinary_array;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst;
  logic            load_valid;
  logic            load_ready;
  logic [2*N-1:0]  load_data;
  logic [1:0]      load_mode;
  logic [DW-1:0]   load_dwell;
  logic            abort;
  logic [2*N-1:0]  state_o;
  logic            all_resolved;
  logic            busy;
  logic            done;
  logic [2:0]      resolve_cnt;
  logic [1:0]      dbg_state_o;
  logic [15:0]     dbg_lfsr_o;

  neutral_trinary_array #(.N_CH(N), .SEED(16'hACE1), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_mode(load_mode), .load_dwell(load_dwell), .abort(abort),
    .state_o(state_o), .all_resolved(all_resolved), .busy(busy), .done(done),
    .resolve_cnt(resolve_cnt), .dbg_state_o(dbg_state_o), .dbg_lfsr_o(dbg_lfsr_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: batch timeline ----------------
  logic [1:0]  m_cells[N];
  logic [1:0]  m_mode;
  logic [15:0] m_lfsr;
  bit          m_active;
  int          m_rel, m_u, m_d, m_rcnt;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cells[i] = 2'b10;
    m_mode = 2'b00; m_lfsr = 16'hACE1; m_active = 0;
    m_rel = 0; m_u = 0; m_d = 0; m_rcnt = 0;
  endtask

  task automatic model_resolve();
    int p, q, k;
    logic [1:0] v;
    p = 0; q = 0; k = -1;
    for (int i = 0; i < N; i++) begin
      if (m_cells[i] == 2'b00) p++;
      if (m_cells[i] == 2'b01) q++;
      if (m_cells[i] == 2'b10 && k < 0) k = i;
    end
    case (m_mode)
      2'b00:   v = m_lfsr[0] ? 2'b01 : 2'b00;
      2'b01:   v = 2'b00;
      2'b10:   v = 2'b01;
      default: v = (p > q) ? 2'b01 : (q > p) ? 2'b00 : (m_lfsr[0] ? 2'b01 : 2'b00);
    endcase
    if (k >= 0) begin
      m_cells[k] = v;
      m_rcnt++;
    end
  endtask

  // Advance the model by one clock edge using the inputs held for the current cycle.
  task automatic model_step();
    int step_len;
    if (!m_active) begin
      if (load_valid) begin
        m_u = 0;
        for (int i = 0; i < N; i++) begin
          m_cells[i] = (load_data[2*i +: 2] == 2'b11) ? 2'b10 : load_data[2*i +: 2];
          if (m_cells[i] == 2'b10) m_u++;
        end
        m_mode = load_mode; m_d = int'(load_dwell);
        m_rcnt = 0; m_rel = 1; m_active = 1;
      end
    end else begin
      step_len = m_d + 1;
      if (m_rel == m_u * step_len + 2) m_active = 0;
      else if (abort) m_active = 0;
      else begin
        if (m_rel <= m_u * step_len && (m_rel % step_len) == 0) model_resolve();
        m_rel++;
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [2*N-1:0] exp_state;
    bit exp_allres;
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      exp_allres = 1;
      for (int i = 0; i < N; i++) begin
        exp_state[2*i +: 2] = m_cells[i];
        if (m_cells[i] == 2'b10) exp_allres = 0;
      end
      check("state_o", 32'(state_o), 32'(exp_state));
      check("all_resolved", 32'(all_resolved), 32'(exp_allres));
      check("load_ready", 32'(load_ready), 32'(!m_active));
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_active && m_rel == m_u * (m_d + 1) + 2));
      check("resolve_cnt", 32'(resolve_cnt), 32'(m_rcnt));
      check("lfsr", 32'(dbg_lfsr_o), 32'(m_lfsr));
      if (!rst) model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a batch for one cycle; returns in cycle 1 of the batch.
  task automatic load_batch(input logic [2*N-1:0] data, input logic [1:0] mode,
                            input logic [DW-1:0] dwell);
    load_valid = 1'b1; load_data = data; load_mode = mode; load_dwell = dwell;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (!done && cyc < start + 300) begin
      tick();
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    n_vec = 0; n_bad = 0;
    rst = 1'b1; load_valid = 1'b0; load_data = '0; load_mode = 2'b00;
    load_dwell = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'h000000AA);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_allres", 32'(all_resolved), 32'd0);
    check("rst_lfsr", 32'(dbg_lfsr_o), 32'h0000ACE1);
    check("model_rst_lfsr", 32'(m_lfsr), 32'h0000ACE1);
    rst = 1'b0;
    tick();
    check("lfsr_step1", 32'(dbg_lfsr_o), 32'h00005670);
    tick();
    check("lfsr_step2", 32'(dbg_lfsr_o), 32'h0000AB38);

    // FORCE_POS, D=0, cells 1 and 3 UNS
    load_batch(8'b10_01_10_00, 2'b01, 8'd0);
    wait_done(1, cyc);
    check("fpos_done_cycle", 32'(cyc), 32'd4);
    check("fpos_state", 32'(state_o), 32'h10);
    check("fpos_rcnt", 32'(resolve_cnt), 32'd2);
    tick();
    check("fpos_ready_again", 32'(load_ready), 32'd1);

    // BALANCE, D=0, two POS already present
    load_batch(8'b10_10_00_00, 2'b11, 8'd0);
    wait_done(1, cyc);
    check("bal_done_cycle", 32'(cyc), 32'd4);
    check("bal_state", 32'(state_o), 32'h50);
    tick();

    // BALANCE tie case, resolved values come from the model
    load_batch(8'b10_10_01_00, 2'b11, 8'd0);
    wait_done(1, cyc);
    check("bal2_done_cycle", 32'(cyc), 32'd4);
    check("bal2_low_cells", 32'(state_o[3:0]), 32'h4);
    check("bal2_rcnt", 32'(resolve_cnt), 32'd2);
    tick();

    // FORCE_NEG, D=3, all UNS
    load_batch(8'hAA, 2'b10, 8'd3);
    repeat (3) tick();
    check("fneg_c4_state", 32'(state_o), 32'hAA);
    tick();
    check("fneg_c5_state", 32'(state_o), 32'hA9);
    wait_done(5, cyc);
    check("fneg_done_cycle", 32'(cyc), 32'd18);
    check("fneg_state", 32'(state_o), 32'h55);
    check("fneg_rcnt", 32'(resolve_cnt), 32'd4);
    tick();

    // abort in cycle 2 of FORCE_POS, D=0, all UNS
    load_batch(8'hAA, 2'b01, 8'd0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(load_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_state", 32'(state_o), 32'hA8);
    check("abort_rcnt", 32'(resolve_cnt), 32'd1);
    tick();
    check("abort_no_done", 32'(done), 32'd0);

    // RANDOM, D=1, all 2'b11 coerced to UNS, with a stray load and mode change mid-batch
    load_batch(8'hFF, 2'b00, 8'd1);
    check("rand_coerced", 32'(state_o), 32'hAA);
    tick();
    load_valid = 1'b1; load_data = 8'h00; load_mode = 2'b01; load_dwell = 8'd0;
    tick();
    load_valid = 1'b0;
    wait_done(3, cyc);
    check("rand_done_cycle", 32'(cyc), 32'd10);
    check("rand_rcnt", 32'(resolve_cnt), 32'd4);
    check("rand_allres", 32'(all_resolved), 32'd1);
    tick();

    // reset in cycle 2 of a batch
    load_batch(8'hAA, 2'b01, 8'd0);
    tick();
    rst = 1'b1;
    #1;
    check("mrst_state", 32'(state_o), 32'hAA);
    check("mrst_ready", 32'(load_ready), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_rcnt", 32'(resolve_cnt), 32'd0);
    check("mrst_lfsr", 32'(dbg_lfsr_o), 32'h0000ACE1);
    tick();
    rst = 1'b0;
    tick();

    // zero-UNS batch: one RUN cycle then done
    load_batch(8'b00_01_01_00, 2'b00, 8'd5);
    wait_done(1, cyc);
    check("zero_done_cycle", 32'(cyc), 32'd2);
    check("zero_rcnt", 32'(resolve_cnt), 32'd0);
    check("zero_state", 32'(state_o), 32'h14);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
